iob_native_mem_resp: RTL and testbench

IOB_NATIVE_MEM_RESP -- requirements
Module: iob_native_mem_resp

---
 rtl/iob_native_mem_resp_pkg.sv | 31 +++
 rtl/iob_sp_ram_be.sv | 40 ++++
 rtl/iob_native_mem_resp.sv | 183 ++++++++++++++++++
 tb/tb_iob_native_mem_resp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_native_mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// iob_native_mem_resp_pkg
// Shared constants for the native-interface memory responder:
//   - FSM state encodings (IDLE/WAIT/RESP)
//   - legal latency range and the width of the latency down-counter
//   - err bit positions
//   - lat_load(): latency to counter load value (LAT-1), clamped to range
// No ports (package).
// -----------------------------------------------------------------------------
package iob_native_mem_resp_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;  // holds LAT_MAX-1

  localparam int ERR_OOR   = 0;
  localparam int ERR_PROTO = 1;

  // Counter load value for a given latency; out-of-range parameters are
  // pulled back into the legal window so the counter can never wrap.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    int l;
    l = (lat < LAT_MIN) ? LAT_MIN : ((lat > LAT_MAX) ? LAT_MAX : lat);
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/iob_sp_ram_be.sv
// -----------------------------------------------------------------------------
// iob_sp_ram_be
// Single-port RAM with per-column (byte) write enables and registered,
// read-first output.
// Ports:
//   clk   in   clock
//   en    in   access enable (read and/or write this edge)
//   we    in   NUM_COL  column write enables (qualified by en)
//   addr  in   ADDR_WIDTH  word address
//   d     in   DATA_WIDTH  write data
//   dout  out  DATA_WIDTH  read data, updated on enabled edges only
// -----------------------------------------------------------------------------
module iob_sp_ram_be #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [NUM_COL-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NUM_COL; i++) begin
        if (we[i]) begin
          mem[addr][i*COL_WIDTH +: COL_WIDTH] <= d[i*COL_WIDTH +: COL_WIDTH];
        end
      end
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/iob_native_mem_resp.sv
// -----------------------------------------------------------------------------
// iob_native_mem_resp
// Native-interface memory responder: accepts one request at a time, touches
// storage exactly once at accept+LAT-1, and returns a one-cycle ready pulse at
// accept+LAT. Tracks out-of-range and protocol errors in sticky flags.
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-low reset
//   valid  in   request strobe (must stay high until completion)
//   addr   in   ADDR_W byte address; word index addr[MEM_ADDR_W+1:2]
//   wdata  in   DATA_W write data
//   wstrb  in   DATA_W/8 byte enables, all-zero = read
//   rdata  out  DATA_W read data, zero unless ready on a read
//   ready  out  single-cycle completion pulse
//   busy   out  accept through ready cycle inclusive
//   err    out  2 sticky: [0] out-of-range, [1] protocol violation
// -----------------------------------------------------------------------------
module iob_native_mem_resp
  import iob_native_mem_resp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int RD_LAT     = 1,
  parameter int WR_LAT     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                busy,
  output logic [1:0]          err
);

  localparam int NB = DATA_W / 8;
  localparam logic [CNT_W-1:0] RD_LOAD = lat_load(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WR_LAT);

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [NB-1:0]     wstrb_reg, wstrb_next;
  logic              oor_reg, oor_next;
  logic              ready_reg, ready_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [1:0]        err_reg, err_next;

  logic                  oor_live, in_wait, last_wait, abort, mismatch;
  logic [CNT_W-1:0]      load_live;
  logic                  use_live, ram_en, sel_oor;
  logic [NB-1:0]         sel_wstrb, ram_we;
  logic [MEM_ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_d, ram_dout;

  generate
    if (ADDR_W > MEM_ADDR_W + 2) begin : g_oor
      assign oor_live = |addr[ADDR_W-1:MEM_ADDR_W+2];
    end else begin : g_no_oor
      assign oor_live = 1'b0;
    end
  endgenerate

  assign in_wait   = (state_reg == ST_WAIT);
  assign load_live = (|wstrb) ? WR_LOAD : RD_LOAD;
  assign abort     = in_wait & ~valid;
  assign last_wait = in_wait & valid & (cnt_reg == CNT_W'(1));
  assign mismatch  = in_wait & valid &
                     ((addr != addr_reg) | (wdata != wdata_reg) | (wstrb != wstrb_reg));

  // LAT=1 touches storage on the accept edge itself, so the live request is
  // used; longer latencies access on the last WAIT edge from the capture regs.
  // Gating with reset keeps a write from landing on the edge reset is taken.
  assign use_live  = (state_reg == ST_IDLE) & valid & (load_live == '0);
  assign ram_en    = reset & (use_live | last_wait);
  assign sel_oor   = use_live ? oor_live : oor_reg;
  assign sel_wstrb = use_live ? wstrb : wstrb_reg;
  assign ram_addr  = use_live ? addr[MEM_ADDR_W+1:2] : addr_reg[MEM_ADDR_W+1:2];
  assign ram_d     = use_live ? wdata : wdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane_we
      assign ram_we[gi] = ram_en & ~sel_oor & sel_wstrb[gi];
    end
  endgenerate

  iob_sp_ram_be #(
    .NUM_COL   (NB),
    .COL_WIDTH (8),
    .ADDR_WIDTH(MEM_ADDR_W)
  ) u_ram (
    .clk (clk),
    .en  (ram_en),
    .we  (ram_we),
    .addr(ram_addr),
    .d   (ram_d),
    .dout(ram_dout)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    wstrb_next = wstrb_reg;
    oor_next   = oor_reg;
    ready_next = 1'b0;
    rdata_next = '0;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        if (valid) begin
          addr_next  = addr;
          wdata_next = wdata;
          wstrb_next = wstrb;
          oor_next   = oor_live;
          cnt_next   = load_live;
          state_next = (load_live == '0) ? ST_RESP : ST_WAIT;
          err_next[ERR_OOR] = err_reg[ERR_OOR] | oor_live;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          err_next[ERR_PROTO] = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1)) begin
            state_next = ST_RESP;
          end
          if (mismatch) begin
            err_next[ERR_PROTO] = 1'b1;
          end
        end
      end
      ST_RESP: begin
        // RAM output still holds the word read on the access edge.
        state_next = ST_IDLE;
        ready_next = 1'b1;
        if ((wstrb_reg == '0) && !oor_reg) begin
          rdata_next = ram_dout;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
      oor_reg   <= 1'b0;
      ready_reg <= 1'b0;
      rdata_reg <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
      oor_reg   <= oor_next;
      ready_reg <= ready_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
    end
  end

  assign rdata = rdata_reg;
  assign ready = ready_reg;
  assign busy  = (state_reg != ST_IDLE) | ready_reg;
  assign err   = err_reg;

endmodule

// File: tb/tb_iob_native_mem_resp.sv
// -----------------------------------------------------------------------------
// tb_iob_native_mem_resp
// Three responders with different latencies share one clock:
//   u0: RD_LAT=1 WR_LAT=1   u1: RD_LAT=4 WR_LAT=2   u2: RD_LAT=2 WR_LAT=3
// Each request pushes {dut, expected ready cycle, expected rdata} into a
// scoreboard queue; a negedge monitor pops on every ready pulse.
// -----------------------------------------------------------------------------
module tb_iob_native_mem_resp;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [ND];
  logic        valid [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wdata [ND];
  logic [3:0]  wstrb [ND];
  logic [31:0] rdata [ND];
  logic        ready [ND];
  logic        busy  [ND];
  logic [1:0]  err   [ND];

  iob_native_mem_resp #(.RD_LAT(1), .WR_LAT(1)) u0 (
    .clk(clk), .reset(reset[0]), .valid(valid[0]), .addr(addr[0]), .wdata(wdata[0]),
    .wstrb(wstrb[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0]));
  iob_native_mem_resp #(.RD_LAT(4), .WR_LAT(2)) u1 (
    .clk(clk), .reset(reset[1]), .valid(valid[1]), .addr(addr[1]), .wdata(wdata[1]),
    .wstrb(wstrb[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1]));
  iob_native_mem_resp #(.RD_LAT(2), .WR_LAT(3)) u2 (
    .clk(clk), .reset(reset[2]), .valid(valid[2]), .addr(addr[2]), .wdata(wdata[2]),
    .wstrb(wstrb[2]), .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .err(err[2]));

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic [31:0] mdl [ND][1024];
  int          cyc = 0;
  bit          mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rd_lat(input int d);
    case (d)
      0:       return 1;
      1:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int wr_lat(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 3;
    endcase
  endfunction

  // Ready monitor: every pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) begin
        if (ready[d]) begin
          if (sb.size() == 0) begin
            check_eq("spurious_ready", 64'(ready[d]), 64'd0);
          end else begin
            e_mon = sb.pop_front();
            check_eq("ready_dut", 64'(d), 64'(e_mon.dut));
            check_eq("ready_cycle", 64'(cyc), 64'(e_mon.cyc));
            check_eq("rdata", 64'(rdata[d]), 64'(e_mon.data));
            check_eq("busy_at_ready", 64'(busy[d]), 64'd1);
            $display("TXN dut=%0d cyc=%0d rdata=0x%08h exp=0x%08h err=%b",
                     d, cyc, rdata[d], e_mon.data, err[d]);
          end
        end else begin
          check_eq("rdata_idle", 64'(rdata[d]), 64'd0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one request (caller sits 1 time unit after a rising edge). keep=1
  // leaves valid high after ready so the next call chains back-to-back;
  // tamper=1 changes addr after accept to provoke a protocol error.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit keep, input bit tamper);
    exp_t e;
    int   lat;
    bit   oor;
    bit   got;
    int   idx;
    oor = (a[31:12] != 20'd0);
    idx = int'(a[11:2]);
    lat = (ws != 4'd0) ? wr_lat(d) : rd_lat(d);
    e.dut = d;
    e.cyc = cyc + 1 + lat;
    e.data = (ws != 4'd0 || oor) ? 32'd0 : mdl[d][idx];
    if (ws != 4'd0 && !oor) begin
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
    sb.push_back(e);
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = ws;
    valid[d] = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy_accept", 64'(busy[d]), 64'd1);
    if (tamper) addr[d] = a ^ 32'h4;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ready[d]) got = 1'b1;
    end
    check_eq("ready_seen", 64'(got), 64'd1);
    if (!keep) valid[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      reset[d] = 1'b0;
      valid[d] = 1'b0;
      addr[d]  = '0;
      wdata[d] = '0;
      wstrb[d] = '0;
    end
    @(posedge clk);
    #1;
    idle(2);
    for (int d = 0; d < ND; d++) begin
      check_eq("rst_ready", 64'(ready[d]), 64'd0);
      check_eq("rst_busy", 64'(busy[d]), 64'd0);
      check_eq("rst_err", 64'(err[d]), 64'd0);
      check_eq("rst_rdata", 64'(rdata[d]), 64'd0);
    end
    for (int d = 0; d < ND; d++) reset[d] = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // ---- u0, LAT=1: write/read, back-to-back reads, out-of-range ----
    do_req(0, 32'h4, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    do_req(0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0);
    check_eq("u0_err_clean", 64'(err[0]), 64'd0);
    do_req(0, 32'h0, 32'hA0A1A2A3, 4'hF, 1'b0, 1'b0);
    do_req(0, 32'h8, 32'hC8C9CACB, 4'hF, 1'b0, 1'b0);
    do_req(0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    do_req(0, 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
    do_req(0, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0);
    idle(4);
    check_eq("u0_b2b_drained", 64'(sb.size()), 64'd0);
    do_req(0, 32'h00010000, 32'h0, 4'h0, 1'b0, 1'b0);
    do_req(0, 32'h00010004, 32'h55555555, 4'hF, 1'b0, 1'b0);
    do_req(0, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0);
    check_eq("u0_err_oor", 64'(err[0]), 64'd1);

    // ---- u1, RD_LAT=4 WR_LAT=2: partial write, b2b, abort ----
    do_req(1, 32'h8, 32'h0, 4'hF, 1'b0, 1'b0);
    do_req(1, 32'h8, 32'h11223344, 4'h5, 1'b0, 1'b0);
    do_req(1, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0);
    check_eq("u1_err_clean", 64'(err[1]), 64'd0);
    do_req(1, 32'h0, 32'h01020304, 4'hF, 1'b0, 1'b0);
    do_req(1, 32'h4, 32'h05060708, 4'hF, 1'b0, 1'b0);
    do_req(1, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    do_req(1, 32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
    do_req(1, 32'h8, 32'h0, 4'h0, 1'b0, 1'b0);
    idle(4);
    check_eq("u1_b2b_drained", 64'(sb.size()), 64'd0);
    addr[1]  = 32'h4;
    wstrb[1] = 4'h0;
    valid[1] = 1'b1;
    idle(1);
    check_eq("u1_abort_busy_on", 64'(busy[1]), 64'd1);
    idle(1);
    valid[1] = 1'b0;
    idle(1);
    check_eq("u1_abort_busy_off", 64'(busy[1]), 64'd0);
    check_eq("u1_abort_err", 64'(err[1]), 64'd2);
    idle(8);
    check_eq("u1_abort_no_ready", 64'(sb.size()), 64'd0);
    do_req(1, 32'h4, 32'h0, 4'h0, 1'b0, 1'b0);

    // ---- u2, RD_LAT=2 WR_LAT=3: reset mid-write, addr change in WAIT ----
    do_req(2, 32'h10, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    addr[2]  = 32'h10;
    wdata[2] = 32'h12345678;
    wstrb[2] = 4'hF;
    valid[2] = 1'b1;
    idle(1);
    reset[2] = 1'b0;
    idle(1);
    valid[2] = 1'b0;
    check_eq("u2_rst_ready", 64'(ready[2]), 64'd0);
    check_eq("u2_rst_busy", 64'(busy[2]), 64'd0);
    check_eq("u2_rst_err", 64'(err[2]), 64'd0);
    check_eq("u2_rst_rdata", 64'(rdata[2]), 64'd0);
    idle(2);
    reset[2] = 1'b1;
    idle(6);
    check_eq("u2_rst_no_ready", 64'(sb.size()), 64'd0);
    do_req(2, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
    check_eq("u2_err_clean", 64'(err[2]), 64'd0);
    do_req(2, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);
    check_eq("u2_err_mismatch", 64'(err[2]), 64'd2);

    idle(5);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
